// File: rtl/mvu_pkg.sv
// rtl/mvu_pkg.sv - shared types and widths for the MVU APB arbiter
package mvu_pkg;

    localparam int NMVU           = 8;
    localparam int APB_ADDR_WIDTH = 32;
    localparam int APB_DATA_WIDTH = 32;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } apb_arb_state_e;

    // Folds v back into [0, n) for v < 2n; avoids a modulo for non-power-of-2 n.
    function automatic int rr_wrap(input int v, input int n);
        return (v >= n) ? (v - n) : v;
    endfunction

endpackage

// File: rtl/mvu_apb_arbiter_rr_arbiter.sv
// rtl/mvu_apb_arbiter_rr_arbiter.sv - combinational round-robin search starting at ptr_i
module rr_arbiter
    import mvu_pkg::*;
#(
    parameter int NREQ  = 8,
    parameter int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic [NREQ-1:0]  req_i,
    input  logic [IDX_W-1:0] ptr_i,
    output logic [NREQ-1:0]  gnt_o,
    output logic [IDX_W-1:0] idx_o,
    output logic             valid_o
);

    logic [IDX_W-1:0] pos;

    always_comb begin
        gnt_o   = '0;
        idx_o   = '0;
        valid_o = 1'b0;
        pos     = '0;
        for (int k = 0; k < NREQ; k++) begin
            pos = IDX_W'(rr_wrap(int'(ptr_i) + k, NREQ));
            if (!valid_o && req_i[pos]) begin
                valid_o    = 1'b1;
                gnt_o[pos] = 1'b1;
                idx_o      = pos;
            end
        end
    end

endmodule

// File: rtl/mvu_apb_arbiter.sv
// rtl/mvu_apb_arbiter.sv - round-robin APB master arbiter; MVU_APB_ARB_TIMEOUT_EN enables ACCESS timeout
module mvu_apb_arbiter
    import mvu_pkg::*;
#(
    parameter int NREQ    = NMVU,
    parameter int ADDR_W  = APB_ADDR_WIDTH,
    parameter int DATA_W  = APB_DATA_WIDTH,
    parameter int TIMEOUT = 64
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic [NREQ-1:0]          req_valid_i,
    output logic [NREQ-1:0]          req_ready_o,
    input  logic [NREQ-1:0]          req_write_i,
    input  logic [NREQ*ADDR_W-1:0]   req_addr_i,
    input  logic [NREQ*DATA_W-1:0]   req_wdata_i,
    output logic [NREQ-1:0]          rsp_valid_o,
    output logic [DATA_W-1:0]        rsp_rdata_o,
    output logic                     rsp_err_o,
    output logic [ADDR_W-1:0]        paddr_o,
    output logic [DATA_W-1:0]        pwdata_o,
    output logic                     psel_o,
    output logic                     penable_o,
    output logic                     pwrite_o,
    input  logic [DATA_W-1:0]        prdata_i,
    input  logic                     pready_i,
    input  logic                     pslverr_i
);

    localparam int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;

    apb_arb_state_e   state_q, state_d;
    logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;
    logic [IDX_W-1:0] gnt_idx_q, gnt_idx_d;
    logic [ADDR_W-1:0] paddr_q, paddr_d;
    logic [DATA_W-1:0] pwdata_q, pwdata_d;
    logic              pwrite_q, pwrite_d;
    logic              psel_q, psel_d;
    logic              penable_q, penable_d;
    logic [NREQ-1:0]   rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
    logic              rsp_err_q, rsp_err_d;

    logic [NREQ-1:0]   arb_gnt;
    logic [IDX_W-1:0]  arb_idx;
    logic              arb_any;
    logic              xfer_tmo;

    rr_arbiter #(
        .NREQ  (NREQ),
        .IDX_W (IDX_W)
    ) u_rr_arbiter (
        .req_i   (req_valid_i),
        .ptr_i   (rr_ptr_q),
        .gnt_o   (arb_gnt),
        .idx_o   (arb_idx),
        .valid_o (arb_any)
    );

    assign req_ready_o = (state_q == IDLE) ? arb_gnt : '0;

`ifdef MVU_APB_ARB_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT + 1);

    logic [TMO_W-1:0] tmo_q;

    // Counts ACCESS cycles; held at zero elsewhere so it starts clean on every entry.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            tmo_q <= '0;
        end else if (state_q == ACCESS) begin
            tmo_q <= tmo_q + 1'b1;
        end else begin
            tmo_q <= '0;
        end
    end

    assign xfer_tmo = (state_q == ACCESS) && !pready_i && (tmo_q == TMO_W'(TIMEOUT - 1));
`else
    assign xfer_tmo = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        gnt_idx_d   = gnt_idx_q;
        paddr_d     = paddr_q;
        pwdata_d    = pwdata_q;
        pwrite_d    = pwrite_q;
        psel_d      = psel_q;
        penable_d   = penable_q;
        rsp_valid_d = '0;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;

        case (state_q)
            IDLE: begin
                if (arb_any) begin
                    state_d   = SETUP;
                    gnt_idx_d = arb_idx;
                    paddr_d   = req_addr_i[arb_idx*ADDR_W +: ADDR_W];
                    pwdata_d  = req_wdata_i[arb_idx*DATA_W +: DATA_W];
                    pwrite_d  = req_write_i[arb_idx];
                    rr_ptr_d  = (arb_idx == IDX_W'(NREQ - 1)) ? '0 : arb_idx + 1'b1;
                    psel_d    = 1'b1;
                    penable_d = 1'b0;
                end
            end
            SETUP: begin
                state_d   = ACCESS;
                penable_d = 1'b1;
            end
            ACCESS: begin
                if (pready_i) begin
                    state_d                = IDLE;
                    psel_d                 = 1'b0;
                    penable_d              = 1'b0;
                    rsp_valid_d[gnt_idx_q] = 1'b1;
                    rsp_rdata_d            = pwrite_q ? '0 : prdata_i;
                    rsp_err_d              = pslverr_i;
                end else if (xfer_tmo) begin
                    state_d                = IDLE;
                    psel_d                 = 1'b0;
                    penable_d              = 1'b0;
                    rsp_valid_d[gnt_idx_q] = 1'b1;
                    rsp_rdata_d            = '0;
                    rsp_err_d              = 1'b1;
                end
            end
            default: begin
                state_d   = IDLE;
                psel_d    = 1'b0;
                penable_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= IDLE;
            rr_ptr_q    <= '0;
            gnt_idx_q   <= '0;
            paddr_q     <= '0;
            pwdata_q    <= '0;
            pwrite_q    <= 1'b0;
            psel_q      <= 1'b0;
            penable_q   <= 1'b0;
            rsp_valid_q <= '0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            gnt_idx_q   <= gnt_idx_d;
            paddr_q     <= paddr_d;
            pwdata_q    <= pwdata_d;
            pwrite_q    <= pwrite_d;
            psel_q      <= psel_d;
            penable_q   <= penable_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    assign paddr_o     = paddr_q;
    assign pwdata_o    = pwdata_q;
    assign pwrite_o    = pwrite_q;
    assign psel_o      = psel_q;
    assign penable_o   = penable_q;
    assign rsp_valid_o = rsp_valid_q;
    assign rsp_rdata_o = rsp_rdata_q;
    assign rsp_err_o   = rsp_err_q;

endmodule
